// File: rtl/q_learning_pkg.sv
// Shared Q-learning types and constants for the Q-table reader/writer pair.
package q_learning_pkg;

  localparam int unsigned NUM_ACTIONS = 4;
  localparam int unsigned STATE_W     = 8;
  localparam int unsigned ACTION_W    = $clog2(NUM_ACTIONS);
  localparam int unsigned Q_W         = 16;
  localparam int unsigned ADDR_W      = STATE_W + ACTION_W;
  localparam int unsigned LFSR_W      = 16;

  typedef logic signed [Q_W-1:0]  q_t;
  typedef logic [STATE_W-1:0]     state_t;
  typedef logic [ACTION_W-1:0]    action_t;

  // FrozenLake action encoding
  typedef enum logic [ACTION_W-1:0] {
    ACT_LEFT  = ACTION_W'(0),
    ACT_DOWN  = ACTION_W'(1),
    ACT_RIGHT = ACTION_W'(2),
    ACT_UP    = ACTION_W'(3)
  } act_e;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_SCAN = 2'd1,
    FSM_RESP = 2'd2
  } fsm_e;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form: feedback from bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  // One LFSR step
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/q_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the exploration random source.
module q_lfsr16
  import q_learning_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [LFSR_W-1:0] lfsr
);

  // Step once per enabled cycle, reload seed on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (enable) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/q_action_select.sv
// Q-table reader: scans all actions of a state, returns argmax action and max Q.
// Optional epsilon-greedy exploration enabled by defining Q_EPSILON_GREEDY_EN.
module q_action_select
  import q_learning_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [STATE_W-1:0]  req_state,
  input  logic [15:0]         epsilon,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [Q_W-1:0]      mem_rd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ACTION_W-1:0] rsp_action,
  output logic [Q_W-1:0]      rsp_max_q,
  output logic                rsp_explored
);

  fsm_e    fsm_q, fsm_d;
  state_t  state_q;
  action_t cmp_act;
  logic    data_vld;
  q_t      best_q;
  action_t best_act;

  logic    explore_q;
  action_t samp_act_q;

  logic    accept_c;
  logic    scan_last_c;
  logic    take_c;
  q_t      rd_q_c;
  q_t      new_best_q_c;
  action_t new_best_act_c;
  action_t iss_act_c;

  assign accept_c  = req_valid && req_ready;
  assign iss_act_c = mem_rd_addr[ACTION_W-1:0];

`ifdef Q_EPSILON_GREEDY_EN
  logic [LFSR_W-1:0] lfsr_c;

  q_lfsr16 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .lfsr   (lfsr_c)
  );

  // Capture the explore decision and random action at the accept edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      explore_q  <= 1'b0;
      samp_act_q <= '0;
    end else if (accept_c) begin
      explore_q  <= (lfsr_c < epsilon);
      samp_act_q <= action_t'(lfsr_c[ACTION_W-1:0]);
    end
  end
`else
  logic unused_epsilon;
  assign unused_epsilon = ^epsilon;
  assign explore_q      = 1'b0;
  assign samp_act_q     = '0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q <= FSM_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_IDLE: if (accept_c)    fsm_d = FSM_SCAN;
      FSM_SCAN: if (scan_last_c) fsm_d = FSM_RESP;
      FSM_RESP: if (rsp_ready)   fsm_d = FSM_IDLE;
      default:                   fsm_d = FSM_IDLE;
    endcase
  end

  // Running argmax: first returned entry seeds best, later ones replace only if strictly greater
  always_comb begin
    rd_q_c         = q_t'(mem_rd_data);
    scan_last_c    = (fsm_q == FSM_SCAN) && data_vld &&
                     (cmp_act == action_t'(NUM_ACTIONS - 1));
    take_c         = (cmp_act == '0) || (rd_q_c > best_q);
    new_best_q_c   = take_c ? rd_q_c  : best_q;
    new_best_act_c = take_c ? cmp_act : best_act;
  end

  // Read issue, compare pipeline and registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_rd_addr  <= '0;
      state_q      <= '0;
      data_vld     <= 1'b0;
      cmp_act      <= '0;
      best_q       <= '0;
      best_act     <= '0;
      rsp_action   <= '0;
      rsp_max_q    <= '0;
      rsp_explored <= 1'b0;
    end else begin
      req_ready <= (fsm_d == FSM_IDLE);
      rsp_valid <= (fsm_d == FSM_RESP);
      data_vld  <= mem_rd_en;

      if (accept_c) begin
        state_q     <= req_state;
        mem_rd_en   <= 1'b1;
        mem_rd_addr <= {req_state, action_t'(0)};
        cmp_act     <= '0;
      end else if (mem_rd_en) begin
        if (iss_act_c == action_t'(NUM_ACTIONS - 1)) begin
          mem_rd_en   <= 1'b0;
          mem_rd_addr <= '0;
        end else begin
          mem_rd_addr <= {state_q, action_t'(iss_act_c + action_t'(1))};
        end
      end

      if ((fsm_q == FSM_SCAN) && data_vld) begin
        best_q   <= new_best_q_c;
        best_act <= new_best_act_c;
        cmp_act  <= action_t'(cmp_act + action_t'(1));
      end

      if (scan_last_c) begin
        rsp_max_q    <= new_best_q_c;
        rsp_action   <= explore_q ? samp_act_q : new_best_act_c;
        rsp_explored <= explore_q;
      end else if ((fsm_q == FSM_RESP) && rsp_ready) begin
        rsp_max_q    <= '0;
        rsp_action   <= '0;
        rsp_explored <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_q_action_select.sv
// Directed bench for q_action_select: vector table plus reset and backpressure sequences.
module tb_q_action_select;
  import q_learning_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic [STATE_W-1:0]  req_state;
  logic [15:0]         epsilon;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [Q_W-1:0]      mem_rd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ACTION_W-1:0] rsp_action;
  logic [Q_W-1:0]      rsp_max_q;
  logic                rsp_explored;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  q_action_select dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_state    (req_state),
    .epsilon      (epsilon),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_action   (rsp_action),
    .rsp_max_q    (rsp_max_q),
    .rsp_explored (rsp_explored)
  );

  // Q-table RAM with one-cycle read latency
  logic [Q_W-1:0] qmem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= qmem[mem_rd_addr];

`ifdef Q_EPSILON_GREEDY_EN
  // Reference LFSR and the value it held at each accept edge
  logic [15:0] lfsr_m;
  logic [15:0] samp_m;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_m <= 16'hACE1;
    end else begin
      lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      if (req_valid && req_ready) samp_m <= lfsr_m;
    end
  end
`endif

  typedef struct {
    logic [7:0]       st;
    logic [3:0][15:0] q;
    logic [1:0]       act;
    logic [15:0]      maxq;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [7:0] st, input logic [15:0] q0, q1, q2, q3,
                              input logic [1:0] act, input logic [15:0] maxq);
    vec_t v;
    v.st   = st;
    v.q    = {q3, q2, q1, q0};
    v.act  = act;
    v.maxq = maxq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int a = 0; a < 4; a++) qmem[{v.st, 2'(a)}] = v.q[a];
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " req_ready"},    32'(req_ready),    0);
    chk({tag, " mem_rd_en"},    32'(mem_rd_en),    0);
    chk({tag, " mem_rd_addr"},  32'(mem_rd_addr),  0);
    chk({tag, " rsp_valid"},    32'(rsp_valid),    0);
    chk({tag, " rsp_action"},   32'(rsp_action),   0);
    chk({tag, " rsp_max_q"},    32'(rsp_max_q),    0);
    chk({tag, " rsp_explored"}, 32'(rsp_explored), 0);
  endtask

  // One full request with cycle-exact checks; rsp_ready assumed high
  task automatic run_vec(input vec_t v, input logic [15:0] eps, input string tag);
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_expl;
    logic [1:0]        exp_act;
    load(v);
    epsilon = eps;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(req_ready), 1);
    req_state = v.st;
    req_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k <= 4) begin
        exp_addr = {v.st, 2'(k - 1)};
        chk($sformatf("%s rd_en c%0d", tag, k), 32'(mem_rd_en), 1);
        chk($sformatf("%s addr c%0d", tag, k), 32'(mem_rd_addr), 32'(exp_addr));
      end else if (k == 5) begin
        chk({tag, " rd_en c5"}, 32'(mem_rd_en), 0);
        chk({tag, " rsp_valid c5"}, 32'(rsp_valid), 0);
      end else begin
`ifdef Q_EPSILON_GREEDY_EN
        exp_expl = (samp_m < eps);
        exp_act  = exp_expl ? samp_m[1:0] : v.act;
`else
        exp_expl = 1'b0;
        exp_act  = v.act;
`endif
        chk({tag, " rsp_valid c6"}, 32'(rsp_valid), 1);
        chk({tag, " rsp_action"}, 32'(rsp_action), 32'(exp_act));
        chk({tag, " rsp_max_q"}, 32'(rsp_max_q), 32'(v.maxq));
        chk({tag, " rsp_explored"}, 32'(rsp_explored), 32'(exp_expl));
      end
    end
    @(negedge clk);
    chk({tag, " rsp_valid after hs"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [1:0]  hold_act;
    logic [15:0] hold_q;
    logic        seen_rsp;

    vecs[0] = mk(8'd5,   16'd10,    16'd40,    16'd25,    16'd3,     2'd1, 16'd40);
    vecs[1] = mk(8'd9,   16'd7,     16'd7,     16'd2,     16'd7,     2'd0, 16'd7);
    vecs[2] = mk(8'd10,  16'd1,     16'd2,     16'd9,     16'd9,     2'd2, 16'd9);
    vecs[3] = mk(8'd0,   16'hFFFB,  16'hFFFD,  16'hFFF8,  16'hFFFD,  2'd1, 16'hFFFD);
    vecs[4] = mk(8'd255, 16'h8000,  16'h8000,  16'h8000,  16'h7FFF,  2'd3, 16'h7FFF);
    vecs[5] = mk(8'd3,   16'h7FFF,  16'h8000,  16'h0000,  16'hFFFF,  2'd0, 16'h7FFF);
    vecs[6] = mk(8'd128, 16'd0,     16'd0,     16'd0,     16'd1,     2'd3, 16'd1);
    vecs[7] = mk(8'd17,  16'hFFFF,  16'h0000,  16'hFFFF,  16'h0000,  2'd1, 16'h0000);

    reset     = 1'b1;
    req_valid = 1'b0;
    req_state = '0;
    epsilon   = '0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk_zero_outputs("in reset");
    reset = 1'b0;
    @(negedge clk);
    chk("req_ready after reset", 32'(req_ready), 1);

    // Greedy table, epsilon zero
    for (int i = 0; i < 8; i++) run_vec(vecs[i], 16'h0000, $sformatf("vec%0d", i));

    // Maximal epsilon: explores with macro, ignored without
    for (int i = 0; i < 8; i++) run_vec(vecs[i], 16'hFFFF, $sformatf("eps_max%0d", i));

    // Reset in SCAN cycle 3 drops the request
    load(vecs[0]);
    @(negedge clk);
    req_state = vecs[0].st;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero_outputs("mid-scan reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("req_ready after mid reset", 32'(req_ready), 1);
    seen_rsp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("no rsp after dropped req", 32'(seen_rsp), 0);

    // Backpressure with a second request waiting
    load(vecs[0]);
    load(vecs[3]);
    epsilon   = 16'h0000;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_state = vecs[0].st;
    req_valid = 1'b1;
    @(negedge clk);
    req_state = vecs[3].st;
    repeat (5) @(negedge clk);
    chk("bp rsp_valid c6", 32'(rsp_valid), 1);
    chk("bp rsp_action", 32'(rsp_action), 1);
    chk("bp rsp_max_q", 32'(rsp_max_q), 40);
    hold_act = rsp_action;
    hold_q   = rsp_max_q;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold valid %0d", c), 32'(rsp_valid), 1);
      chk($sformatf("bp hold action %0d", c), 32'(rsp_action), 32'(hold_act));
      chk($sformatf("bp hold max_q %0d", c), 32'(rsp_max_q), 32'(hold_q));
      chk($sformatf("bp req_ready %0d", c), 32'(req_ready), 0);
      chk($sformatf("bp mem_rd_en %0d", c), 32'(mem_rd_en), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp rsp_valid after hs", 32'(rsp_valid), 0);
    chk("bp req_ready after hs", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp next rd_en", 32'(mem_rd_en), 1);
    chk("bp next addr", 32'(mem_rd_addr), 32'({vecs[3].st, 2'd0}));
    repeat (5) @(negedge clk);
    chk("bp next rsp_valid", 32'(rsp_valid), 1);
    chk("bp next rsp_action", 32'(rsp_action), 32'(vecs[3].act));
    chk("bp next rsp_max_q", 32'(rsp_max_q), 32'(vecs[3].maxq));
    @(negedge clk);

    // Epsilon zero over many requests: always greedy
    for (int i = 0; i < 100; i++) run_vec(vecs[i % 8], 16'h0000, $sformatf("eps0_%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
